// File: rtl/ukf_pkg.sv
// Shared definitions for the UKF host-side sequencer: frame geometry,
// counter width and the 2-bit sequencer state encoding.
package ukf_pkg;

  localparam int unsigned UKF_N_MEAS      = 3;
  localparam int unsigned UKF_DATA_W      = 32;
  localparam int unsigned UKF_FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } ukf_seq_state_t;

endpackage

// File: rtl/ukf_meas_fifo.sv
// Synchronous measurement-frame FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// The head (dout) is read combinationally from storage.
module ukf_meas_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Frame storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ukf_sequencer.sv
// Host-side initiator for the UKF core start/done handshake. Buffers
// measurement frames, launches one iteration per frame, holds the frame on
// ukf_meas for the iteration and counts completed iterations.
// Optional feature macro: UKF_SEQ_WATCHDOG_EN (WAIT watchdog + sticky
// timeout_err). Without it WAIT exits only on ukf_done.
module ukf_sequencer
  import ukf_pkg::*;
#(
  parameter int unsigned DATA_W         = UKF_DATA_W,
  parameter int unsigned N_MEAS         = UKF_N_MEAS,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       meas_valid,
  output logic                       meas_ready,
  input  logic [N_MEAS*DATA_W-1:0]   meas_data,
  output logic                       ukf_start,
  input  logic                       ukf_done,
  output logic [N_MEAS*DATA_W-1:0]   ukf_meas,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       err_clr,
  output logic [UKF_FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]                 state_dbg
);

  localparam int unsigned FW = N_MEAS * DATA_W;
  localparam logic [UKF_FRAME_CNT_W-1:0] CNT_ONE = UKF_FRAME_CNT_W'(1);

  ukf_seq_state_t             state_q, state_d;
  logic [FW-1:0]              meas_q;
  logic [UKF_FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FW-1:0]              fifo_dout;
  logic                       pop;
  logic                       wd_fire;

  assign pop        = (state_q == ST_IDLE) & enable & ~fifo_empty;
  assign meas_ready = ~fifo_full;

  ukf_meas_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (meas_valid & ~fifo_full),
    .pop   (pop),
    .din   (meas_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

`ifdef UKF_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // done has priority over an expiring watchdog in the same cycle.
  assign wd_fire = (state_q == ST_WAIT) & ~ukf_done & (wd_q == WD_LAST);

  // Watchdog count: held at zero outside WAIT, so it is clear on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst)                    wd_q <= '0;
    else if (state_q != ST_WAIT) wd_q <= '0;
    else                        wd_q <= wd_q + WD_ONE;
  end

  // Sticky timeout flag; a firing timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (wd_fire) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign wd_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Next-state and completion-count logic; ukf_done only matters in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ukf_done) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_ONE;
        end else if (wd_fire) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counter and held frame registers; the frame changes only on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      meas_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) meas_q <= fifo_dout;
    end
  end

  assign ukf_start = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;
  assign ukf_meas  = meas_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_ukf_sequencer.sv
// Self-checking bench for ukf_sequencer: a frame-queue / iteration-age
// reference model checked every cycle, a vector table for a single
// iteration, directed corner sequences and a randomized phase.
module tb_ukf_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned NM    = 3;
  localparam int unsigned FW    = DW * NM;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;
`ifdef UKF_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          enable;
  logic          meas_valid;
  logic          meas_ready;
  logic [FW-1:0] meas_data;
  logic          ukf_start;
  logic          ukf_done;
  logic [FW-1:0] ukf_meas;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;
  logic [15:0]   frame_cnt;
  logic [1:0]    state_dbg;

  ukf_sequencer #(
    .DATA_W         (DW),
    .N_MEAS         (NM),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_data   (meas_data),
    .ukf_start   (ukf_start),
    .ukf_done    (ukf_done),
    .ukf_meas    (ukf_meas),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .frame_cnt   (frame_cnt),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: frames waiting, plus the in-flight iteration described
  // by its age in cycles since the pop (0 load, 1 start, >=2 waiting).
  logic [FW-1:0] mq[$];
  bit            inflight = 1'b0;
  int            age      = 0;
  logic [FW-1:0] m_meas   = '0;
  logic [15:0]   m_cnt    = '0;
  bit            m_err    = 1'b0;
  bit            last_push;

  logic [FW-1:0] started_q[$];
  int            start_cyc[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit         rdy_pre;
    bit         fire;
    logic [1:0] es;
    rdy_pre = (mq.size() < DEPTH);
    @(posedge clk);
    cyc++;
    last_push = 1'b0;
    if (rst) begin
      mq.delete();
      inflight = 1'b0;
      age      = 0;
      m_meas   = '0;
      m_cnt    = '0;
      m_err    = 1'b0;
    end else begin
      fire = 1'b0;
      if (inflight) begin
        if (age >= 2 && ukf_done) begin
          inflight = 1'b0;
          m_cnt    = m_cnt + 16'd1;
        end else if (WD && age >= TO + 1) begin
          inflight = 1'b0;
          fire     = 1'b1;
        end else begin
          age++;
        end
      end else if (enable && mq.size() > 0) begin
        m_meas   = mq.pop_front();
        inflight = 1'b1;
        age      = 0;
      end
      if (fire) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (meas_valid && rdy_pre) begin
        mq.push_back(meas_data);
        last_push = 1'b1;
      end
    end
    #1;
    es = !inflight ? 2'd0 : (age >= 2) ? 2'd3 : 2'(age + 1);
    chk("meas_ready", meas_ready, mq.size() < DEPTH);
    chk("ukf_start", ukf_start, inflight && age == 1);
    chk("ukf_meas", ukf_meas, m_meas);
    chk("busy", busy, inflight);
    chk("timeout_err", timeout_err, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("state_dbg", state_dbg, es);
    if (ukf_start === 1'b1) begin
      started_q.push_back(ukf_meas);
      start_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    meas_valid = 1'b0;
    ukf_done = 1'b0;
    err_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    meas_valid = 1'b1;
    meas_data  = d;
    step();
    meas_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 12 && ukf_start !== 1'b1; i++) step();
    chk(name, ukf_start, 1'b1);
  endtask

  typedef struct {
    bit            valid;
    logic [FW-1:0] data;
    bit            done;
    bit            exp_start;
    logic [1:0]    exp_state;
    logic [15:0]   exp_cnt;
    bit            exp_ready;
    logic [FW-1:0] exp_meas;
  } vec_t;

  vec_t          tbl[9];
  logic [FW-1:0] burst[6];
  logic [FW-1:0] f1;
  int            accepted;
  int            n_before;

  initial begin
    rst = 1'b1; enable = 1'b1; meas_valid = 1'b0; meas_data = '0;
    ukf_done = 1'b0; err_clr = 1'b0;
    f1 = {32'h0000_0020, 32'h0000_0010, 32'h0000_0064};

    //            valid data done start state cnt ready meas
    tbl[0] = '{1'b1, f1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, '0};
    tbl[1] = '{1'b0, '0, 1'b0, 1'b0, 2'd1, 16'd0, 1'b1, f1};
    tbl[2] = '{1'b0, '0, 1'b0, 1'b1, 2'd2, 16'd0, 1'b1, f1};
    tbl[3] = '{1'b0, '0, 1'b0, 1'b0, 2'd3, 16'd0, 1'b1, f1};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b0, 2'd3, 16'd0, 1'b1, f1};
    tbl[5] = '{1'b0, '0, 1'b0, 1'b0, 2'd3, 16'd0, 1'b1, f1};
    tbl[6] = '{1'b0, '0, 1'b0, 1'b0, 2'd3, 16'd0, 1'b1, f1};
    tbl[7] = '{1'b0, '0, 1'b1, 1'b0, 2'd0, 16'd1, 1'b1, f1};
    tbl[8] = '{1'b0, '0, 1'b0, 1'b0, 2'd0, 16'd1, 1'b1, f1};

    // Reset state
    do_reset();
    chk("rst_start", ukf_start, 1'b0);
    chk("rst_meas", ukf_meas, '0);
    chk("rst_ready", meas_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_cnt", frame_cnt, 16'd0);
    chk("rst_state", state_dbg, 2'd0);

    // Single frame, table driven
    for (int i = 0; i < 9; i++) begin
      meas_valid = tbl[i].valid;
      meas_data  = tbl[i].data;
      ukf_done   = tbl[i].done;
      step();
      chk("tbl_start", ukf_start, tbl[i].exp_start);
      chk("tbl_state", state_dbg, tbl[i].exp_state);
      chk("tbl_cnt", frame_cnt, tbl[i].exp_cnt);
      chk("tbl_ready", meas_ready, tbl[i].exp_ready);
      chk("tbl_meas", ukf_meas, tbl[i].exp_meas);
    end
    meas_valid = 1'b0; ukf_done = 1'b0;

    // Burst of 6 with done withheld, then released
    do_reset();
    started_q.delete();
    for (int k = 0; k < 6; k++) burst[k] = {32'(k * 3 + 2), 32'(k * 3 + 1), 32'(k * 3)};
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      meas_valid = (accepted < 6);
      meas_data  = burst[accepted < 6 ? accepted : 5];
      step();
      if (last_push) accepted++;
    end
    chk("burst_accepted", accepted, 5);
    chk("burst_ready_low", meas_ready, 1'b0);
    ukf_done = 1'b1;
    for (int i = 0; i < 80 && frame_cnt !== 16'd6; i++) begin
      meas_valid = (accepted < 6);
      meas_data  = burst[accepted < 6 ? accepted : 5];
      step();
      if (last_push) accepted++;
    end
    meas_valid = 1'b0; ukf_done = 1'b0;
    chk("burst_cnt", frame_cnt, 16'd6);
    chk("burst_nstart", started_q.size(), 6);
    for (int k = 0; k < 6 && k < started_q.size(); k++) chk("burst_order", started_q[k], burst[k]);

    // Watchdog: done never returned
    do_reset();
    push_frame(96'h1111);
    for (int i = 0; i < 25; i++) step();
`ifdef UKF_SEQ_WATCHDOG_EN
    chk("wd_terr", timeout_err, 1'b1);
    chk("wd_state", state_dbg, 2'd0);
    chk("wd_cnt", frame_cnt, 16'd0);
`else
    chk("nowd_terr", timeout_err, 1'b0);
    chk("nowd_state", state_dbg, 2'd3);
    ukf_done = 1'b1; step(); ukf_done = 1'b0;
`endif
    push_frame(96'h2222);
    wait_start("wd_next_start");
    chk("wd_next_meas", ukf_meas, 96'h2222);
    for (int i = 0; i < 3; i++) step();
    ukf_done = 1'b1; step(); ukf_done = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("wd_clr", timeout_err, 1'b0);
    // err_clr held through a timeout: the set must win on that cycle
    err_clr = 1'b1;
    push_frame(96'h3333);
    for (int i = 0; i < 22; i++) step();
    err_clr = 1'b0;
    ukf_done = 1'b1; step(); step(); ukf_done = 1'b0;

    // done coincident with ukf_start is ignored
    do_reset();
    push_frame(96'h4444);
    wait_start("dstart_start");
    ukf_done = 1'b1; step(); ukf_done = 1'b0;
    chk("dstart_wait", state_dbg, 2'd3);
    chk("dstart_cnt", frame_cnt, 16'd0);
    for (int i = 0; i < 3; i++) step();
    chk("dstart_still", state_dbg, 2'd3);
    ukf_done = 1'b1; step(); ukf_done = 1'b0;
    chk("dstart_done", frame_cnt, 16'd1);

    // enable low blocks launch; raising it launches back-to-back
    do_reset();
    enable = 1'b0;
    n_before = start_cyc.size();
    push_frame(96'h5555);
    push_frame(96'h6666);
    for (int i = 0; i < 6; i++) step();
    chk("en_nostart", start_cyc.size() - n_before, 0);
    chk("en_busy", busy, 1'b0);
    enable = 1'b1; ukf_done = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ukf_done = 1'b0;
    chk("en_nstart", start_cyc.size() - n_before, 2);
    if (start_cyc.size() - n_before == 2)
      chk("en_gap", start_cyc[n_before + 1] - start_cyc[n_before], 4);
    chk("en_cnt", frame_cnt, 16'd2);

    // Reset during WAIT with 3 frames queued
    do_reset();
    for (int k = 0; k < 4; k++) push_frame(96'(32'h7000 + k));
    for (int i = 0; i < 10 && state_dbg !== 2'd3; i++) step();
    chk("rw_inwait", state_dbg, 2'd3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rw_start", ukf_start, 1'b0);
    chk("rw_meas", ukf_meas, '0);
    chk("rw_ready", meas_ready, 1'b1);
    chk("rw_busy", busy, 1'b0);
    chk("rw_state", state_dbg, 2'd0);
    n_before = start_cyc.size();
    for (int i = 0; i < 10; i++) step();
    chk("rw_nostart", start_cyc.size() - n_before, 0);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      meas_valid = 1'($urandom_range(0, 1));
      meas_data  = {$urandom, $urandom, $urandom};
      ukf_done   = ($urandom_range(0, 3) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; meas_valid = 1'b0; ukf_done = 1'b0; err_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
